// File: rtl/reg_writeback_pkg.sv
// Shared widths and result type for the writeback stage and its scoreboard.
package reg_writeback_pkg;

  localparam int RegIdWidth = 5;
  localparam int RegWidth   = 32;
  localparam int RegCnt     = 32;

  typedef logic [RegIdWidth-1:0] reg_id_t;
  typedef logic [RegWidth-1:0]   reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_id_t   rd;
    reg_data_t wdata;
  } wb_result_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Result, issue, hazard-query, write-port and forwarding signals of the writeback stage.
interface reg_writeback_if import reg_writeback_pkg::*; ();

  logic      alu_valid;
  reg_id_t   alu_rd;
  reg_data_t alu_wdata;

  logic      lsu_valid;
  logic      lsu_ready;
  reg_id_t   lsu_rd;
  reg_data_t lsu_wdata;

  logic      issue_valid;
  logic      issue_ready;
  reg_id_t   issue_rd;

  reg_id_t   rs1;
  reg_id_t   rs2;
  logic      rs1_busy;
  logic      rs2_busy;

  logic      reg_wen;
  reg_id_t   rd;
  reg_data_t reg_wdata;

  logic      rs1_fwd;
  logic      rs2_fwd;
  reg_data_t rs1_fwd_data;
  reg_data_t rs2_fwd_data;

  modport master (
    output alu_valid, alu_rd, alu_wdata,
    output lsu_valid, lsu_rd, lsu_wdata,
    input  lsu_ready,
    output issue_valid, issue_rd,
    input  issue_ready,
    output rs1, rs2,
    input  rs1_busy, rs2_busy,
    input  reg_wen, rd, reg_wdata,
    input  rs1_fwd, rs2_fwd, rs1_fwd_data, rs2_fwd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_wdata,
    input  lsu_valid, lsu_rd, lsu_wdata,
    output lsu_ready,
    input  issue_valid, issue_rd,
    output issue_ready,
    input  rs1, rs2,
    output rs1_busy, rs2_busy,
    output reg_wen, rd, reg_wdata,
    output rs1_fwd, rs2_fwd, rs1_fwd_data, rs2_fwd_data
  );

endinterface

// File: rtl/reg_writeback_wb_scoreboard.sv
// Per-register 2-bit pending-write counters: gate issue when saturated, answer busy queries.
module wb_scoreboard import reg_writeback_pkg::*; (
  input  logic    clk,
  input  logic    rst,
  input  logic    issue_valid_i,
  input  reg_id_t issue_rd_i,
  output logic    issue_ready_o,
  input  logic    dec_valid_i,
  input  reg_id_t dec_rd_i,
  input  reg_id_t rs1_i,
  input  reg_id_t rs2_i,
  output logic    rs1_busy_o,
  output logic    rs2_busy_o
);

  logic [1:0] pending_q [RegCnt];
  logic [1:0] pending_d [RegCnt];
  logic       issue_fire;

  // A retiring result frees a slot in the same cycle, so a saturated register may still issue.
  assign issue_ready_o = !((pending_q[issue_rd_i] == 2'd3) &&
                           !(dec_valid_i && dec_rd_i == issue_rd_i));
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

  assign rs1_busy_o = (pending_q[rs1_i] != 2'd0);
  assign rs2_busy_o = (pending_q[rs2_i] != 2'd0);

  always_comb begin
    // NOTE: combinational blocks assign a full default first and use blocking '=' so no latch is inferred.
    pending_d = pending_q;
    for (int r = 1; r < RegCnt; r++) begin
      if (issue_fire && issue_rd_i == RegIdWidth'(r) &&
          !(dec_valid_i && dec_rd_i == RegIdWidth'(r))) begin
        pending_d[r] = pending_q[r] + 2'd1;
      end else if (dec_valid_i && dec_rd_i == RegIdWidth'(r) &&
                   !(issue_fire && issue_rd_i == RegIdWidth'(r)) &&
                   pending_q[r] != 2'd0) begin
        pending_d[r] = pending_q[r] - 2'd1;
      end
    end
    pending_d[0] = 2'd0;
  end

  always_ff @(posedge clk) begin
    // NOTE: the counter array is reset explicitly; a reset must discard every in-flight write.
    if (rst) begin
      for (int r = 0; r < RegCnt; r++) pending_q[r] <= 2'd0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: ALU-priority arbitration, registered regfile write, scoreboard, forwarding.
// Define WB_FORWARD_EN to build the forwarding paths; otherwise forwarding outputs are tied 0.
module reg_writeback import reg_writeback_pkg::*; (
  input logic            clk,
  input logic            rst,
  reg_writeback_if.slave wb
);

  wb_result_t acc;
  logic       write;
  logic       reg_wen_q, reg_wen_d;
  reg_id_t    rd_q, rd_d;
  reg_data_t  wdata_q, wdata_d;

  assign wb.lsu_ready = !wb.alu_valid;

  always_comb begin
    acc = '0;
    if (wb.alu_valid) begin
      acc = '{valid: 1'b1, rd: wb.alu_rd, wdata: wb.alu_wdata};
    end else if (wb.lsu_valid) begin
      acc = '{valid: 1'b1, rd: wb.lsu_rd, wdata: wb.lsu_wdata};
    end
  end

  // x0 results are consumed but never reach the register file or scoreboard.
  assign write = acc.valid && (acc.rd != '0);

  always_comb begin
    reg_wen_d = write;
    rd_d      = write ? acc.rd    : rd_q;
    wdata_d   = write ? acc.wdata : wdata_q;
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wen_q <= 1'b0;
      rd_q      <= '0;
      wdata_q   <= '0;
    end else begin
      reg_wen_q <= reg_wen_d;
      rd_q      <= rd_d;
      wdata_q   <= wdata_d;
    end
  end

  assign wb.reg_wen   = reg_wen_q;
  assign wb.rd        = rd_q;
  assign wb.reg_wdata = wdata_q;

  wb_scoreboard u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (wb.issue_valid),
    .issue_rd_i    (wb.issue_rd),
    .issue_ready_o (wb.issue_ready),
    .dec_valid_i   (write),
    .dec_rd_i      (acc.rd),
    .rs1_i         (wb.rs1),
    .rs2_i         (wb.rs2),
    .rs1_busy_o    (wb.rs1_busy),
    .rs2_busy_o    (wb.rs2_busy)
  );

`ifdef WB_FORWARD_EN
  assign wb.rs1_fwd      = reg_wen_q && (rd_q == wb.rs1) && (wb.rs1 != '0);
  assign wb.rs2_fwd      = reg_wen_q && (rd_q == wb.rs2) && (wb.rs2 != '0);
  assign wb.rs1_fwd_data = wdata_q;
  assign wb.rs2_fwd_data = wdata_q;
`else
  assign wb.rs1_fwd      = 1'b0;
  assign wb.rs2_fwd      = 1'b0;
  assign wb.rs1_fwd_data = '0;
  assign wb.rs2_fwd_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: arbitration, scoreboard, x0, reset and forwarding outputs.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reg_writeback_if wb_bus ();

  reg_writeback dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb_bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; inputs change only in this window.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_bus.alu_valid   = 1'b0;
    wb_bus.lsu_valid   = 1'b0;
    wb_bus.issue_valid = 1'b0;
    #1;
  endtask

  initial begin
    wb_bus.alu_valid = 1'b0; wb_bus.alu_rd = '0; wb_bus.alu_wdata = '0;
    wb_bus.lsu_valid = 1'b0; wb_bus.lsu_rd = '0; wb_bus.lsu_wdata = '0;
    wb_bus.issue_valid = 1'b0; wb_bus.issue_rd = '0;
    wb_bus.rs1 = '0; wb_bus.rs2 = '0;

    // Traffic during reset is dropped; handshake outputs keep their rules.
    rst = 1'b1;
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd4; wb_bus.alu_wdata = 32'h55;
    wb_bus.issue_valid = 1'b1; wb_bus.issue_rd = 5'd4;
    #1;
    check("rst_lsu_ready", wb_bus.lsu_ready, 0);
    check("rst_issue_ready", wb_bus.issue_ready, 1);
    step();
    rst = 1'b0;
    idle();
    wb_bus.rs1 = 5'd4; #1;
    check("rst_reg_wen", wb_bus.reg_wen, 0);
    check("rst_rd", wb_bus.rd, 0);
    check("rst_wdata", wb_bus.reg_wdata, 0);
    check("rst_busy4", wb_bus.rs1_busy, 0);

    // Single ALU write
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd5; wb_bus.alu_wdata = 32'h1234; #1;
    check("alu_lsu_ready", wb_bus.lsu_ready, 0);
    step(); idle();
    check("alu_wen", wb_bus.reg_wen, 1);
    check("alu_rd", wb_bus.rd, 5);
    check("alu_wdata", wb_bus.reg_wdata, 32'h1234);
    step();
    check("idle_wen", wb_bus.reg_wen, 0);
    check("idle_rd_hold", wb_bus.rd, 5);
    check("idle_wdata_hold", wb_bus.reg_wdata, 32'h1234);

    // ALU and LSU together: ALU first, LSU once ALU drops
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd6; wb_bus.alu_wdata = 32'h1111;
    wb_bus.lsu_valid = 1'b1; wb_bus.lsu_rd = 5'd8; wb_bus.lsu_wdata = 32'h2222; #1;
    check("arb_lsu_ready0", wb_bus.lsu_ready, 0);
    step();
    wb_bus.alu_valid = 1'b0; #1;
    check("arb_lsu_ready1", wb_bus.lsu_ready, 1);
    check("arb_alu_rd", wb_bus.rd, 6);
    check("arb_alu_wdata", wb_bus.reg_wdata, 32'h1111);
    step(); idle();
    check("arb_lsu_wen", wb_bus.reg_wen, 1);
    check("arb_lsu_rd", wb_bus.rd, 8);
    check("arb_lsu_wdata", wb_bus.reg_wdata, 32'h2222);
    step();
    check("arb_done_wen", wb_bus.reg_wen, 0);

    // Saturate pending[7]
    wb_bus.rs1 = 5'd7;
    wb_bus.issue_valid = 1'b1; wb_bus.issue_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("sat_ready_%0d", i), wb_bus.issue_ready, 1);
      step();
    end
    check("sat_ready_full", wb_bus.issue_ready, 0);
    check("sat_busy7", wb_bus.rs1_busy, 1);
    wb_bus.issue_valid = 1'b0;
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd7; wb_bus.alu_wdata = 32'h77; #1;
    check("sat_ready_bypass", wb_bus.issue_ready, 1);
    step(); idle();
    check("ret1_ready", wb_bus.issue_ready, 1);
    check("ret1_busy", wb_bus.rs1_busy, 1);
    wb_bus.lsu_valid = 1'b1; wb_bus.lsu_rd = 5'd7; wb_bus.lsu_wdata = 32'h78;
    step(); idle();
    check("ret2_wdata", wb_bus.reg_wdata, 32'h78);
    check("ret2_busy", wb_bus.rs1_busy, 1);
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd7; wb_bus.alu_wdata = 32'h79;
    step(); idle();
    check("ret3_busy", wb_bus.rs1_busy, 0);

    // x0 result: no write, scoreboard untouched
    wb_bus.rs2 = 5'd9;
    wb_bus.issue_valid = 1'b1; wb_bus.issue_rd = 5'd9;
    step(); idle();
    check("x0_pre_busy9", wb_bus.rs2_busy, 1);
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd0; wb_bus.alu_wdata = 32'hFF;
    step(); idle();
    check("x0_wen", wb_bus.reg_wen, 0);
    check("x0_busy9", wb_bus.rs2_busy, 1);

    // Issue and retire of rd 9 in the same cycle leave pending[9] at 1
    wb_bus.issue_valid = 1'b1; wb_bus.issue_rd = 5'd9;
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd9; wb_bus.alu_wdata = 32'h99;
    step(); idle();
    check("coin_wen", wb_bus.reg_wen, 1);
    check("coin_busy9", wb_bus.rs2_busy, 1);
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd9; wb_bus.alu_wdata = 32'h9A;
    step(); idle();
    check("coin_retire_busy9", wb_bus.rs2_busy, 0);

    // Result with nothing pending: written, counter stays 0
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd9; wb_bus.alu_wdata = 32'h9B;
    step(); idle();
    check("uflow_wen", wb_bus.reg_wen, 1);
    check("uflow_wdata", wb_bus.reg_wdata, 32'h9B);
    check("uflow_busy9", wb_bus.rs2_busy, 0);
    wb_bus.issue_valid = 1'b1; wb_bus.issue_rd = 5'd9;
    step(); idle();
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd9;
    step(); idle();
    check("uflow_after_busy9", wb_bus.rs2_busy, 0);

    // Forwarding outputs
    wb_bus.rs1 = 5'd3; wb_bus.rs2 = 5'd4;
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd3; wb_bus.alu_wdata = 32'hABCD;
    step(); idle();
`ifdef WB_FORWARD_EN
    check("fwd_rs1", wb_bus.rs1_fwd, 1);
    check("fwd_rs1_data", wb_bus.rs1_fwd_data, 32'hABCD);
`else
    check("fwd_rs1", wb_bus.rs1_fwd, 0);
    check("fwd_rs1_data", wb_bus.rs1_fwd_data, 0);
`endif
    check("fwd_rs2", wb_bus.rs2_fwd, 0);
    wb_bus.rs1 = 5'd0; #1;
    check("fwd_rs1_x0", wb_bus.rs1_fwd, 0);

    // Reset mid-stream discards pending state and the in-flight result
    wb_bus.rs1 = 5'd10;
    wb_bus.issue_valid = 1'b1; wb_bus.issue_rd = 5'd10;
    step(); step(); idle();
    check("mid_pre_busy10", wb_bus.rs1_busy, 1);
    rst = 1'b1;
    wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 5'd11; wb_bus.alu_wdata = 32'hBEEF;
    step();
    rst = 1'b0; idle();
    check("mid_wen", wb_bus.reg_wen, 0);
    check("mid_busy10", wb_bus.rs1_busy, 0);
    check("mid_rd", wb_bus.rd, 0);
    step();
    check("mid_wen_after", wb_bus.reg_wen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset is synchronous and active-high.
REQ-003 SHALL have ports alu_valid (in, 1), alu_rd (in, RegIdWidth), alu_wdata (in, RegWidth): single-cycle result source, no backpressure.
REQ-004 SHALL have ports lsu_valid (in, 1), lsu_ready (out, 1), lsu_rd (in, RegIdWidth), lsu_wdata (in, RegWidth): multicycle result source, valid/ready handshake.
REQ-005 SHALL have ports issue_valid (in, 1), issue_ready (out, 1), issue_rd (in, RegIdWidth): decode announces a future write to issue_rd.
REQ-006 SHALL have ports rs1, rs2 (in, RegIdWidth) and rs1_busy, rs2_busy (out, 1): hazard query.
REQ-007 SHALL have ports reg_wen (out, 1), rd (out, RegIdWidth), reg_wdata (out, RegWidth): register-file write port.
REQ-008 SHALL have ports rs1_fwd, rs2_fwd (out, 1) and rs1_fwd_data, rs2_fwd_data (out, RegWidth): forwarding results.

Function
REQ-009 SHALL register the winning result into reg_wen/rd/reg_wdata; latency source-accept to reg_wen high = 1 cycle.
REQ-010 SHALL give ALU priority: alu_valid accepted every cycle it is high.
REQ-011 SHALL drive lsu_ready = !alu_valid (combinational); LSU transfer occurs only when lsu_valid && lsu_ready.
REQ-012 SHALL hold reg_wen low in any cycle following no accepted result; rd and reg_wdata hold last value.
REQ-013 SHALL drive reg_wen low for accepted results with rd == 0; scoreboard untouched for x0.
REQ-014 SHALL keep a 2-bit pending counter per register, RegCnt entries; entry 0 always 0.
REQ-015 SHALL increment pending[issue_rd] on issue_valid && issue_ready && issue_rd != 0.
REQ-016 SHALL decrement pending[r] on the edge a result for r != 0 is accepted.
REQ-017 SHALL leave pending[r] unchanged when increment and decrement of r coincide.
REQ-018 SHALL drive issue_ready low when pending[issue_rd] == 3 and no decrement of issue_rd occurs that cycle; otherwise high.
REQ-019 SHALL drive rsN_busy = (pending[rsN] != 0), combinational; rs = 0 never busy.
REQ-020 Accepted result with pending[r] == 0 SHALL still be written; counter SHALL not underflow (stays 0).

Reset
REQ-021 On rst high at posedge: all pending counters 0, reg_wen 0, rd 0, reg_wdata 0.
REQ-022 Results and issues presented during the reset cycle SHALL be dropped; lsu_ready and issue_ready follow their rules unchanged.
REQ-023 Reset mid-operation SHALL discard all in-flight pending state with no write emitted the following cycle.

Configuration
REQ-024 Macro WB_FORWARD_EN defined: rsN_fwd = reg_wen && rd == rsN && rsN != 0, rsN_fwd_data = reg_wdata.
REQ-025 WB_FORWARD_EN undefined: rsN_fwd tied 0, rsN_fwd_data tied 0; no forwarding logic synthesized.

Structure
REQ-026 RegIdWidth, RegWidth, RegCnt SHALL come from the shared defines package; a wb_result_t typedef (valid, rd, wdata) SHALL be added there.
REQ-027 One sub-module SHALL be used: wb_scoreboard (pending counters, issue_ready, busy outputs).

Verification
REQ-028 alu_valid=1, alu_rd=5, alu_wdata=0x1234 -> next cycle reg_wen=1, rd=5, reg_wdata=0x1234.
REQ-029 alu_valid=1 and lsu_valid=1 same cycle -> lsu_ready=0; ALU written first; LSU written the cycle after alu_valid drops.
REQ-030 issue rd=7 three times -> rs1=7 busy, issue_ready=0 on fourth; one ALU result to 7 -> issue_ready=1, still busy until three results retire.
REQ-031 alu_rd=0, alu_wdata=0xFF -> reg_wen stays 0, all pending unchanged.
REQ-032 issue rd=9 and result rd=9 same cycle with pending[9]=1 -> pending[9] stays 1, rs2=9 busy.
REQ-033 WB_FORWARD_EN defined, write rd=3 data=0xABCD, rs1=3 -> rs1_fwd=1, rs1_fwd_data=0xABCD; rst mid-stream -> all busy 0, reg_wen 0.
